// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad entry controller:
//   - key codes for the non-digit keys (clear, backspace, enter)
//   - FSM state encoding
//   - is_digit() helper used by the entry FSM
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_edge_sync.sv
// ---------------------------------------------------------------------------
// keypad_edge_sync
// Two-flop synchroniser plus rising-edge detector for the keypad level.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   level  : asynchronous key-held level from the scanner
//   rise   : one-cycle pulse on a rising edge of the synchronised level
// A rising edge is only reported once the synchronised level has been seen
// low after reset, so a key already held at reset release produces no event.
// ---------------------------------------------------------------------------
module keypad_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic sync_p0, sync_p1, prev_p2;
  // vld_pN marks that sync_pN holds a real sample taken after reset
  logic vld_p0, vld_p1;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      // stage 0: first metastability flop
      sync_p0 <= level;
      vld_p0  <= 1'b1;
      // stage 1: synchronised level
      sync_p1 <= sync_p0;
      vld_p1  <= vld_p0;
      // stage 2: delayed copy for edge detection
      prev_p2 <= sync_p1;
      if (vld_p1 && !sync_p1)
        armed <= 1'b1;
    end
  end

  assign rise = armed & sync_p1 & ~prev_p2;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_entry_ctrl
// Collects BCD digits from a keypad scanner into an entry buffer and hands
// the committed number to a consumer with a valid/ready handshake.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   key_pressed : scanner level, high while a key is held
//   key_val     : scanner key code (0-9 digit, A clear, E backspace, F enter)
//   num_bcd     : entered number, BCD, least-significant digit in [3:0]
//   digit_cnt   : digits currently held
//   num_valid   : committed number available
//   num_ready   : consumer accepts the number
//   overflow    : one-cycle pulse when a digit is rejected (buffer full)
// Build option: define KEYPAD_TIMEOUT_EN to abandon an entry after
// TIMEOUT_CYCLES idle cycles in ENTRY.
// ---------------------------------------------------------------------------
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_pressed,
  input  logic [3:0]            key_val,
  output logic [4*DIGITS-1:0]   num_bcd,
  output logic [3:0]            digit_cnt,
  output logic                  num_valid,
  input  logic                  num_ready,
  output logic                  overflow
);

  localparam int W = 4 * DIGITS;

  logic            key_evt;
  logic            timeout_hit;
  state_t          state, state_nxt;
  logic [W-1:0]    bcd_nxt;
  logic [3:0]      cnt_nxt;
  logic            ovf_nxt;

  keypad_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .level (key_pressed),
    .rise  (key_evt)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  // Counts idle cycles only while an entry is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (key_evt || state != ST_ENTRY)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_ENTRY) && !key_evt &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      num_bcd   <= '0;
      digit_cnt <= '0;
      num_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      num_bcd   <= bcd_nxt;
      digit_cnt <= cnt_nxt;
      // Registered from the next state so it never follows num_ready
      // combinationally
      num_valid <= (state_nxt == ST_COMMIT);
      overflow  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcd_nxt   = num_bcd;
    cnt_nxt   = digit_cnt;
    ovf_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_evt && is_digit(key_val)) begin
          bcd_nxt   = W'(key_val);
          cnt_nxt   = 4'd1;
          state_nxt = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (timeout_hit) begin
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (key_evt) begin
          if (is_digit(key_val)) begin
            if (digit_cnt < 4'(DIGITS)) begin
              bcd_nxt = (num_bcd << 4) | W'(key_val);
              cnt_nxt = digit_cnt + 4'd1;
            end else begin
              ovf_nxt = 1'b1;
            end
          end else begin
            case (key_val)
              KEY_CLEAR: begin
                bcd_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
              end
              KEY_BKSP: begin
                bcd_nxt = num_bcd >> 4;
                cnt_nxt = digit_cnt - 4'd1;
                if (digit_cnt == 4'd1)
                  state_nxt = ST_IDLE;
              end
              KEY_ENTER: state_nxt = ST_COMMIT;
              default: ;
            endcase
          end
        end
      end
      ST_COMMIT: begin
        // num_valid is high throughout COMMIT, so ready alone completes it
        if (num_ready) begin
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        bcd_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_entry_ctrl
// Self-checking bench for keypad_entry_ctrl (DIGITS=4). Define
// KEYPAD_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
// ---------------------------------------------------------------------------
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int TO     = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_pressed = 1'b0;
  logic [3:0]  key_val = 4'h0;
  logic        num_ready = 1'b0;
  logic [15:0] num_bcd;
  logic [3:0]  digit_cnt;
  logic        num_valid;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // monitor counters (written only by the monitor)
  int          ovf_seen = 0;
  int          valid_seen = 0;
  logic [15:0] v_bcd = '0;
  logic [3:0]  v_cnt = '0;

  // reference model state
  int q[$];
  bit committed;
  int ovf_exp;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pressed (key_pressed),
    .key_val     (key_val),
    .num_bcd     (num_bcd),
    .digit_cnt   (digit_cnt),
    .num_valid   (num_valid),
    .num_ready   (num_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow) ovf_seen <= ovf_seen + 1;
    if (num_valid) begin
      valid_seen <= valid_seen + 1;
      v_bcd      <= num_bcd;
      v_cnt      <= digit_cnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_val     = k;
    key_pressed = 1'b1;
    repeat (4) @(negedge clk);
    key_pressed = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    key_pressed = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic int model_bcd();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  function automatic void model_key(input int k);
    if (committed) return;
    if (k <= 9) begin
      if (q.size() < DIGITS) q.push_back(k);
      else ovf_exp++;
    end else if (k == 10) begin
      q.delete();
    end else if (k == 14) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (k == 15) begin
      if (q.size() > 0) committed = 1'b1;
    end
  endfunction

  typedef struct {
    logic [3:0]  key;
    logic [15:0] bcd;
    logic [3:0]  cnt;
    logic        vld;
    int          ovf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int ov0, vs0;
    tbl[0]  = '{4'h4, 16'h0004, 4'd1, 1'b0, 0};
    tbl[1]  = '{4'h5, 16'h0045, 4'd2, 1'b0, 0};
    tbl[2]  = '{4'h6, 16'h0456, 4'd3, 1'b0, 0};
    tbl[3]  = '{4'h7, 16'h4567, 4'd4, 1'b0, 0};
    tbl[4]  = '{4'h8, 16'h4567, 4'd4, 1'b0, 1};
    tbl[5]  = '{4'hE, 16'h0456, 4'd3, 1'b0, 1};
    tbl[6]  = '{4'hB, 16'h0456, 4'd3, 1'b0, 1};
    tbl[7]  = '{4'hA, 16'h0000, 4'd0, 1'b0, 1};
    tbl[8]  = '{4'hE, 16'h0000, 4'd0, 1'b0, 1};
    tbl[9]  = '{4'hF, 16'h0000, 4'd0, 1'b0, 1};
    tbl[10] = '{4'h0, 16'h0000, 4'd1, 1'b0, 1};
    tbl[11] = '{4'h9, 16'h0009, 4'd2, 1'b0, 1};
    tbl[12] = '{4'hF, 16'h0009, 4'd2, 1'b1, 1};
    tbl[13] = '{4'h3, 16'h0009, 4'd2, 1'b1, 1};

    // reset state while rst_n is held low
    #1;
    check("reset_bcd",   32'(num_bcd),   32'h0);
    check("reset_cnt",   32'(digit_cnt), 32'h0);
    check("reset_valid", 32'(num_valid), 32'h0);
    check("reset_ovf",   32'(overflow),  32'h0);

    // table-driven vectors, consumer not ready
    do_reset();
    ov0 = ovf_seen;
    for (int i = 0; i < 14; i++) begin
      press(tbl[i].key);
      check($sformatf("tbl%0d_bcd", i),   32'(num_bcd),   32'(tbl[i].bcd));
      check($sformatf("tbl%0d_cnt", i),   32'(digit_cnt), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_valid", i), 32'(num_valid), 32'(tbl[i].vld));
      check($sformatf("tbl%0d_ovf", i),   32'(ovf_seen - ov0), 32'(tbl[i].ovf));
    end
    num_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("tbl_hs_valid", 32'(num_valid), 32'h0);
    check("tbl_hs_bcd",   32'(num_bcd),   32'h0);
    check("tbl_hs_cnt",   32'(digit_cnt), 32'h0);

    // 1,2,3,F with ready held high: one valid cycle carrying 0x123
    do_reset();
    num_ready = 1'b1;
    vs0 = valid_seen;
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    check("commit_valid_cycles", 32'(valid_seen - vs0), 32'd1);
    check("commit_bcd",          32'(v_bcd), 32'h0123);
    check("commit_cnt",          32'(v_cnt), 32'd3);
    check("commit_after_bcd",    32'(num_bcd), 32'h0);
    check("commit_after_valid",  32'(num_valid), 32'h0);

    // backspace down to empty, then enter must be ignored in IDLE
    do_reset();
    num_ready = 1'b0;
    press(4'h9); press(4'h8);
    check("bksp_98", 32'(num_bcd), 32'h0098);
    press(4'hE);
    check("bksp_9",  32'(num_bcd), 32'h0009);
    check("bksp_9_cnt", 32'(digit_cnt), 32'd1);
    press(4'hE);
    check("bksp_0",  32'(num_bcd), 32'h0000);
    check("bksp_0_cnt", 32'(digit_cnt), 32'd0);
    press(4'hF);
    check("bksp_idle_enter", 32'(num_valid), 32'h0);

    // commit stall with a key pressed meanwhile
    do_reset();
    num_ready = 1'b0;
    press(4'h5); press(4'hF);
    press(4'h7);
    repeat (10) @(negedge clk);
    check("stall_valid", 32'(num_valid), 32'h1);
    check("stall_bcd",   32'(num_bcd),   32'h0005);
    check("stall_cnt",   32'(digit_cnt), 32'd1);
    num_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_hs_valid", 32'(num_valid), 32'h0);
    check("stall_hs_bcd",   32'(num_bcd),   32'h0);

    // held key stores exactly one digit
    do_reset();
    num_ready = 1'b0;
    @(negedge clk);
    key_val = 4'h6;
    key_pressed = 1'b1;
    repeat (1000) @(negedge clk);
    key_pressed = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_cnt", 32'(digit_cnt), 32'd1);
    check("hold_bcd", 32'(num_bcd),   32'h0006);

    // asynchronous reset during COMMIT
    do_reset();
    press(4'h2); press(4'hF);
    check("arst_pre_valid", 32'(num_valid), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(num_valid), 32'h0);
    check("arst_bcd",   32'(num_bcd),   32'h0);
    repeat (2) @(negedge clk);

    // key held across reset release produces no event
    key_val = 4'h5;
    key_pressed = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_rel_cnt", 32'(digit_cnt), 32'd0);
    key_pressed = 1'b0;
    repeat (5) @(negedge clk);
    press(4'h2);
    check("rst_rel_after_bcd", 32'(num_bcd), 32'h0002);

`ifdef KEYPAD_TIMEOUT_EN
    do_reset();
    press(4'h3);
    repeat (TO + 10) @(negedge clk);
    check("timeout_bcd", 32'(num_bcd),   32'h0);
    check("timeout_cnt", 32'(digit_cnt), 32'h0);
    press(4'hF);
    check("timeout_idle", 32'(num_valid), 32'h0);
`else
    do_reset();
    press(4'h3);
    repeat (4 * TO) @(negedge clk);
    check("persist_bcd", 32'(num_bcd),   32'h0003);
    check("persist_cnt", 32'(digit_cnt), 32'd1);
`endif

    // randomized presses against the reference model
    do_reset();
    q.delete();
    committed = 1'b0;
    ovf_exp = 0;
    ov0 = ovf_seen;
    for (int n = 0; n < 300; n++) begin
      int r, k;
      bit rdy;
      r = $urandom_range(0, 99);
      if (r < 60) k = $urandom_range(0, 9);
      else        k = $urandom_range(10, 15);
      rdy = ($urandom_range(0, 3) == 0);
      if (committed && rdy) begin committed = 1'b0; q.delete(); end
      model_key(k);
      if (committed && rdy) begin committed = 1'b0; q.delete(); end
      num_ready = rdy;
      press(4'(k));
      check($sformatf("rnd%0d_bcd", n),   32'(num_bcd),   32'(model_bcd()));
      check($sformatf("rnd%0d_cnt", n),   32'(digit_cnt), 32'(q.size()));
      check($sformatf("rnd%0d_valid", n), 32'(num_valid), 32'(committed));
      check($sformatf("rnd%0d_ovf", n),   32'(ovf_seen - ov0), 32'(ovf_exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
